// File: rtl/alu_ctrl_pkg.sv
// Shared constants for the ID->EX ALU control stage: ALU codes, MIPS opcode/funct
// values and the stage occupancy state.
package alu_ctrl_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

endpackage

// File: rtl/alu_ctrl_if.sv
// ID->EX handshake bundle: the ID-side master presents instructions, the stage
// (slave) returns the registered ALU operands and control.
interface alu_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int OPC_W  = 6
);
    logic              in_valid;
    logic              in_ready;
    logic [OPC_W-1:0]  opcode;
    logic [OPC_W-1:0]  funct;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [15:0]       imm16;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [3:0]        alu_control;
    logic [DATA_W-1:0] alu_in1;
    logic [DATA_W-1:0] alu_in2;
    logic              illegal;

    modport master (
        output in_valid, opcode, funct, rs_data, rt_data, imm16, flush, out_ready,
        input  in_ready, out_valid, alu_control, alu_in1, alu_in2, illegal
    );

    modport slave (
        input  in_valid, opcode, funct, rs_data, rt_data, imm16, flush, out_ready,
        output in_ready, out_valid, alu_control, alu_in1, alu_in2, illegal
    );
endinterface

// File: rtl/alu_ctrl_decode.sv
// Combinational MIPS opcode/funct decode to ALUControl plus second-operand select.
// Undecodable instructions yield AND with a zero operand and raise illegal.
module alu_ctrl_decode
    import alu_ctrl_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int OPC_W  = 6
) (
    input  logic [OPC_W-1:0]  i_opcode,
    input  logic [OPC_W-1:0]  i_funct,
    input  logic [15:0]       i_imm16,
    input  logic [DATA_W-1:0] i_rt_data,
    output logic [3:0]        o_alu_control,
    output logic [DATA_W-1:0] o_alu_in2,
    output logic              o_illegal
);

    logic [DATA_W-1:0] w_imm_sext;
    logic [DATA_W-1:0] w_imm_zext;

    assign w_imm_sext = {{(DATA_W-16){i_imm16[15]}}, i_imm16};
    assign w_imm_zext = {{(DATA_W-16){1'b0}}, i_imm16};

    always_comb begin
        o_alu_control = ALU_AND;
        o_alu_in2     = '0;
        o_illegal     = 1'b0;
        case (i_opcode)
            OPC_W'(OP_RTYPE): begin
                o_alu_in2 = i_rt_data;
                case (i_funct)
                    OPC_W'(FN_ADD): o_alu_control = ALU_ADD;
                    OPC_W'(FN_SUB): o_alu_control = ALU_SUB;
                    OPC_W'(FN_AND): o_alu_control = ALU_AND;
                    OPC_W'(FN_OR):  o_alu_control = ALU_OR;
                    OPC_W'(FN_SLT): o_alu_control = ALU_SLT;
                    default: begin
                        o_alu_in2 = '0;
                        o_illegal = 1'b1;
                    end
                endcase
            end
            OPC_W'(OP_LW), OPC_W'(OP_SW), OPC_W'(OP_ADDI): begin
                o_alu_control = ALU_ADD;
                o_alu_in2     = w_imm_sext;
            end
            OPC_W'(OP_SLTI): begin
                o_alu_control = ALU_SLT;
                o_alu_in2     = w_imm_sext;
            end
            OPC_W'(OP_ANDI): begin
                o_alu_control = ALU_AND;
                o_alu_in2     = w_imm_zext;
            end
            OPC_W'(OP_ORI): begin
                o_alu_control = ALU_OR;
                o_alu_in2     = w_imm_zext;
            end
            OPC_W'(OP_BEQ): begin
                o_alu_control = ALU_SUB;
                o_alu_in2     = i_rt_data;
            end
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_ctrl_stage.sv
// ID->EX pipeline register driving the ALU, with valid/ready, stall and flush.
// Optional macro ALU_CTRL_ILLEGAL_CNT_EN adds a saturating illegal-instruction counter.
//
// state | meaning
// EMPTY | no operation presented to the ALU (out_valid=0)
// FULL  | operation held for the EX stage (out_valid=1)
module alu_ctrl_stage
    import alu_ctrl_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int OPC_W  = 6
) (
    input  logic        clk,
    input  logic        rst,
    alu_ctrl_if.slave   bus
`ifdef ALU_CTRL_ILLEGAL_CNT_EN
    ,
    output logic [15:0] o_illegal_cnt
`endif
);

    state_t            r_state;
    logic [3:0]        r_alu_control;
    logic [DATA_W-1:0] r_alu_in1;
    logic [DATA_W-1:0] r_alu_in2;
    logic              r_illegal;

    logic              w_in_ready;
    logic              w_transfer;
    logic [3:0]        w_dec_control;
    logic [DATA_W-1:0] w_dec_in2;
    logic              w_dec_illegal;

    alu_ctrl_decode #(
        .DATA_W (DATA_W),
        .OPC_W  (OPC_W)
    ) u_decode (
        .i_opcode      (bus.opcode),
        .i_funct       (bus.funct),
        .i_imm16       (bus.imm16),
        .i_rt_data     (bus.rt_data),
        .o_alu_control (w_dec_control),
        .o_alu_in2     (w_dec_in2),
        .o_illegal     (w_dec_illegal)
    );

    assign w_in_ready = (r_state == EMPTY) || bus.out_ready;
    assign w_transfer = bus.in_valid && w_in_ready;

    assign bus.in_ready    = w_in_ready;
    assign bus.out_valid   = (r_state == FULL);
    assign bus.alu_control = r_alu_control;
    assign bus.alu_in1     = r_alu_in1;
    assign bus.alu_in2     = r_alu_in2;
    assign bus.illegal     = r_illegal;

    // Flush wins over everything; data registers keep their last value on drain/flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= EMPTY;
            r_alu_control <= ALU_AND;
            r_alu_in1     <= '0;
            r_alu_in2     <= '0;
            r_illegal     <= 1'b0;
        end else if (bus.flush) begin
            r_state   <= EMPTY;
            r_illegal <= 1'b0;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_transfer) begin
                        r_state       <= FULL;
                        r_alu_control <= w_dec_control;
                        r_alu_in1     <= bus.rs_data;
                        r_alu_in2     <= w_dec_in2;
                        r_illegal     <= w_dec_illegal;
                    end
                end
                FULL: begin
                    if (w_transfer) begin
                        r_alu_control <= w_dec_control;
                        r_alu_in1     <= bus.rs_data;
                        r_alu_in2     <= w_dec_in2;
                        r_illegal     <= w_dec_illegal;
                    end else if (bus.out_ready) begin
                        r_state <= EMPTY;
                    end
                end
                default: r_state <= EMPTY;
            endcase
        end
    end

`ifdef ALU_CTRL_ILLEGAL_CNT_EN
    logic [15:0] r_illegal_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_illegal_cnt <= '0;
        end else if (w_transfer && w_dec_illegal && !bus.flush && (r_illegal_cnt != 16'hFFFF)) begin
            r_illegal_cnt <= r_illegal_cnt + 16'd1;
        end
    end

    assign o_illegal_cnt = r_illegal_cnt;
`endif

endmodule

// File: tb/tb_alu_ctrl_stage.sv
// Self-checking bench for alu_ctrl_stage: reference model compared every cycle,
// plus directed vectors with hand-computed literal expectations.
module tb_alu_ctrl_stage;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_ctrl_if #(.DATA_W(32), .OPC_W(6)) bus ();

`ifdef ALU_CTRL_ILLEGAL_CNT_EN
    logic [15:0] illegal_cnt;
`endif

    alu_ctrl_stage #(.DATA_W(32), .OPC_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef ALU_CTRL_ILLEGAL_CNT_EN
        ,
        .o_illegal_cnt (illegal_cnt)
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference decode: {illegal, alu_control, alu_in2}
    function automatic logic [36:0] ref_decode(input logic [5:0] op, input logic [5:0] fn,
                                               input logic [15:0] imm, input logic [31:0] rt);
        logic [31:0] sx;
        logic [31:0] zx;
        sx = {{16{imm[15]}}, imm};
        zx = {16'h0000, imm};
        if (op == 6'h00) begin
            if (fn == 6'h20) return {1'b0, 4'b0010, rt};
            if (fn == 6'h22) return {1'b0, 4'b0110, rt};
            if (fn == 6'h24) return {1'b0, 4'b0000, rt};
            if (fn == 6'h25) return {1'b0, 4'b0001, rt};
            if (fn == 6'h2A) return {1'b0, 4'b0111, rt};
            return {1'b1, 4'b0000, 32'h0};
        end
        if (op == 6'h23 || op == 6'h2B || op == 6'h08) return {1'b0, 4'b0010, sx};
        if (op == 6'h0A) return {1'b0, 4'b0111, sx};
        if (op == 6'h0C) return {1'b0, 4'b0000, zx};
        if (op == 6'h0D) return {1'b0, 4'b0001, zx};
        if (op == 6'h04) return {1'b0, 4'b0110, rt};
        return {1'b1, 4'b0000, 32'h0};
    endfunction

    logic        m_valid = 1'b0;
    logic [3:0]  m_ctrl  = 4'h0;
    logic [31:0] m_in1   = 32'h0;
    logic [31:0] m_in2   = 32'h0;
    logic        m_ill   = 1'b0;
    int          m_cnt   = 0;
    logic [36:0] m_dec;

    assign m_dec = ref_decode(bus.opcode, bus.funct, bus.imm16, bus.rt_data);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid <= 1'b0;
            m_ctrl  <= 4'h0;
            m_in1   <= 32'h0;
            m_in2   <= 32'h0;
            m_ill   <= 1'b0;
            m_cnt   <= 0;
        end else if (bus.flush) begin
            m_valid <= 1'b0;
            m_ill   <= 1'b0;
        end else if (bus.in_valid && (!m_valid || bus.out_ready)) begin
            m_valid <= 1'b1;
            m_ill   <= m_dec[36];
            m_ctrl  <= m_dec[35:32];
            m_in2   <= m_dec[31:0];
            m_in1   <= bus.rs_data;
            if (m_dec[36] && m_cnt < 65535) m_cnt <= m_cnt + 1;
        end else if (bus.out_ready) begin
            m_valid <= 1'b0;
        end
    end

    always @(negedge clk) begin
        chk("cmp_out_valid", 32'(bus.out_valid), 32'(m_valid));
        chk("cmp_in_ready", 32'(bus.in_ready), 32'(!m_valid || bus.out_ready));
        chk("cmp_alu_control", 32'(bus.alu_control), 32'(m_ctrl));
        chk("cmp_alu_in1", bus.alu_in1, m_in1);
        chk("cmp_alu_in2", bus.alu_in2, m_in2);
        chk("cmp_illegal", 32'(bus.illegal), 32'(m_ill));
`ifdef ALU_CTRL_ILLEGAL_CNT_EN
        chk("cmp_illegal_cnt", 32'(illegal_cnt), 32'(m_cnt));
`endif
    end

    task automatic step(input logic v, input logic [5:0] op, input logic [5:0] fn,
                        input logic [31:0] rs, input logic [31:0] rt, input logic [15:0] imm,
                        input logic ordy, input logic fl);
        bus.in_valid  = v;
        bus.opcode    = op;
        bus.funct     = fn;
        bus.rs_data   = rs;
        bus.rt_data   = rt;
        bus.imm16     = imm;
        bus.out_ready = ordy;
        bus.flush     = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string name, input logic v, input logic [3:0] c,
                           input logic [31:0] a1, input logic [31:0] a2, input logic il);
        chk({name, "_valid"}, 32'(bus.out_valid), 32'(v));
        chk({name, "_ctrl"}, 32'(bus.alu_control), 32'(c));
        chk({name, "_in1"}, bus.alu_in1, a1);
        chk({name, "_in2"}, bus.alu_in2, a2);
        chk({name, "_illegal"}, 32'(bus.illegal), 32'(il));
    endtask

    typedef struct {
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [15:0] imm;
        logic [31:0] rt;
        logic [3:0]  ctrl;
        logic [31:0] in2;
    } vec_t;

    vec_t vecs[10];

    initial begin
        vecs[0] = '{6'h08, 6'h00, 16'hFFFF, 32'h0000_1111, 4'b0010, 32'hFFFF_FFFF};
        vecs[1] = '{6'h0D, 6'h00, 16'hFFFF, 32'h0000_1111, 4'b0001, 32'h0000_FFFF};
        vecs[2] = '{6'h0A, 6'h00, 16'h8000, 32'h0000_1111, 4'b0111, 32'hFFFF_8000};
        vecs[3] = '{6'h0C, 6'h00, 16'h8000, 32'h0000_1111, 4'b0000, 32'h0000_8000};
        vecs[4] = '{6'h23, 6'h00, 16'h0010, 32'h0000_1111, 4'b0010, 32'h0000_0010};
        vecs[5] = '{6'h2B, 6'h00, 16'hFFFC, 32'h0000_1111, 4'b0010, 32'hFFFF_FFFC};
        vecs[6] = '{6'h00, 6'h22, 16'h0000, 32'h0000_0003, 4'b0110, 32'h0000_0003};
        vecs[7] = '{6'h00, 6'h24, 16'h0000, 32'h0000_00F0, 4'b0000, 32'h0000_00F0};
        vecs[8] = '{6'h00, 6'h25, 16'h0000, 32'h0000_000F, 4'b0001, 32'h0000_000F};
        vecs[9] = '{6'h00, 6'h2A, 16'h1234, 32'h8000_0000, 4'b0111, 32'h8000_0000};

        bus.in_valid  = 1'b0;
        bus.opcode    = 6'h00;
        bus.funct     = 6'h00;
        bus.rs_data   = 32'h0;
        bus.rt_data   = 32'h0;
        bus.imm16     = 16'h0;
        bus.out_ready = 1'b0;
        bus.flush     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_out("reset", 1'b0, 4'b0000, 32'h0, 32'h0, 1'b0);
        chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
        rst = 1'b0;

        // Reset then add
        step(1'b1, 6'h00, 6'h20, 32'd5, 32'd7, 16'h0, 1'b1, 1'b0);
        chk_out("add", 1'b1, 4'b0010, 32'd5, 32'd7, 1'b0);

        // Decode table, back-to-back
        for (int i = 0; i < 10; i++) begin
            step(1'b1, vecs[i].op, vecs[i].fn, 32'(100 + i), vecs[i].rt, vecs[i].imm, 1'b1, 1'b0);
            chk_out($sformatf("vec%0d", i), 1'b1, vecs[i].ctrl, 32'(100 + i), vecs[i].in2, 1'b0);
        end

        // EX stall
        step(1'b1, 6'h04, 6'h00, 32'd9, 32'd3, 16'h0, 1'b1, 1'b0);
        chk_out("beq", 1'b1, 4'b0110, 32'd9, 32'd3, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 6'h00, 6'h20, 32'd11, 32'd12, 16'h0, 1'b0, 1'b0);
            chk_out("hold", 1'b1, 4'b0110, 32'd9, 32'd3, 1'b0);
            chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
        end
        step(1'b1, 6'h00, 6'h20, 32'd11, 32'd12, 16'h0, 1'b1, 1'b0);
        chk_out("after_hold", 1'b1, 4'b0010, 32'd11, 32'd12, 1'b0);
        step(1'b0, 6'h00, 6'h20, 32'd0, 32'd0, 16'h0, 1'b1, 1'b0);
        chk_out("drain", 1'b0, 4'b0010, 32'd11, 32'd12, 1'b0);

        // Flush priority over transfer and over hold
        step(1'b1, 6'h00, 6'h22, 32'd20, 32'd4, 16'h0, 1'b1, 1'b0);
        step(1'b1, 6'h00, 6'h20, 32'd77, 32'd1, 16'h0, 1'b1, 1'b1);
        chk_out("flush_xfer", 1'b0, 4'b0110, 32'd20, 32'd4, 1'b0);
        step(1'b0, 6'h00, 6'h20, 32'd0, 32'd0, 16'h0, 1'b1, 1'b0);
        chk_out("flush_gone", 1'b0, 4'b0110, 32'd20, 32'd4, 1'b0);
        step(1'b1, 6'h00, 6'h24, 32'd30, 32'd6, 16'h0, 1'b1, 1'b0);
        step(1'b1, 6'h00, 6'h20, 32'd40, 32'd1, 16'h0, 1'b0, 1'b0);
        chk_out("pre_flush_hold", 1'b1, 4'b0000, 32'd30, 32'd6, 1'b0);
        step(1'b1, 6'h00, 6'h20, 32'd40, 32'd1, 16'h0, 1'b0, 1'b1);
        chk_out("flush_hold", 1'b0, 4'b0000, 32'd30, 32'd6, 1'b0);

        // Illegal instructions
        step(1'b1, 6'h3F, 6'h00, 32'd50, 32'd51, 16'h1234, 1'b1, 1'b0);
        chk_out("ill_op", 1'b1, 4'b0000, 32'd50, 32'd0, 1'b1);
        step(1'b1, 6'h00, 6'h21, 32'd52, 32'd53, 16'h0, 1'b1, 1'b0);
        chk_out("ill_fn", 1'b1, 4'b0000, 32'd52, 32'd0, 1'b1);
        step(1'b1, 6'h3F, 6'h3F, 32'd54, 32'd55, 16'hFFFF, 1'b1, 1'b0);
        chk_out("ill_op2", 1'b1, 4'b0000, 32'd54, 32'd0, 1'b1);
`ifdef ALU_CTRL_ILLEGAL_CNT_EN
        chk("ill_cnt3", 32'(illegal_cnt), 32'd3);
`endif
        step(1'b1, 6'h3F, 6'h00, 32'd56, 32'd57, 16'h0, 1'b1, 1'b1);
        chk_out("ill_flushed", 1'b0, 4'b0000, 32'd54, 32'd0, 1'b0);
        step(1'b1, 6'h00, 6'h25, 32'd58, 32'd59, 16'h0, 1'b1, 1'b0);
        chk_out("legal_after_ill", 1'b1, 4'b0001, 32'd58, 32'd59, 1'b0);
`ifdef ALU_CTRL_ILLEGAL_CNT_EN
        chk("ill_cnt_flush", 32'(illegal_cnt), 32'd3);
`endif

        // Async reset in the middle of a hold
        step(1'b1, 6'h00, 6'h20, 32'd61, 32'd62, 16'h0, 1'b1, 1'b0);
        step(1'b1, 6'h00, 6'h20, 32'd63, 32'd64, 16'h0, 1'b0, 1'b0);
        chk_out("pre_rst_hold", 1'b1, 4'b0010, 32'd61, 32'd62, 1'b0);
        #3 rst = 1'b1;
        #1;
        chk_out("async_rst", 1'b0, 4'b0000, 32'h0, 32'h0, 1'b0);
`ifdef ALU_CTRL_ILLEGAL_CNT_EN
        chk("async_rst_cnt", 32'(illegal_cnt), 32'd0);
`endif
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        chk_out("post_rst_accept", 1'b1, 4'b0010, 32'd63, 32'd64, 1'b0);

        step(1'b0, 6'h00, 6'h00, 32'd0, 32'd0, 16'h0, 1'b1, 1'b0);
        step(1'b0, 6'h00, 6'h00, 32'd0, 32'd0, 16'h0, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
